multicycle_ctrl: RTL and testbench

Parametrised multi-cycle CPU control unit. It sequences fetch, decode and execute for a single-bus datapath (PC, MAR, MDR, IR, SP, Y) by driving load (`l_*`) and tri-state (`t_*`) enables. It adds three things the first-generation controller lacked:
- a memory ready/wait handshake with timeout fault;
- stack push/pop;
- explicit reset, halt and illegal-opcode handling.

---
 rtl/multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for a single-bus datapath: fetch/decode/execute sequencing with
// memory wait handshake, timeout fault, stack push/pop, halt and illegal-opcode reporting.
module multicycle_ctrl #(
    parameter int unsigned IR_W    = 16,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic            l_pc,
    output logic            l_mar,
    output logic            l_mdr,
    output logic            l_ir,
    output logic            l_sp,
    output logic            l_y,
    output logic            t_pc,
    output logic            t_mar,
    output logic            t_mdr,
    output logic            t_ir,
    output logic            t_sp,
    output logic            t_y,
    output logic            inc_pc,
    output logic            inc_sp,
    output logic            dec_sp,
    output logic            y,
    output logic            mem_active,
    output logic            rd_wr,
    output logic [3:0]      state,
    output logic            retire,
    output logic            err_illegal,
    output logic            fault,
    output logic            halted
);

    typedef enum logic [3:0] {
        StFetch0 = 4'd0,
        StFetch1 = 4'd1,
        StFetch2 = 4'd2,
        StDecode = 4'd3,
        StExa    = 4'd4,
        StMemRd  = 4'd5,
        StMemWr  = 4'd6,
        StWb     = 4'd7,
        StHalt   = 4'd14,
        StFault  = 4'd15
    } state_e;

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpLoad  = 4'h1;
    localparam logic [3:0] OpStore = 4'h2;
    localparam logic [3:0] OpPush  = 4'h3;
    localparam logic [3:0] OpPop   = 4'h4;
    localparam logic [3:0] OpJmp   = 4'h5;
    localparam logic [3:0] OpAlu   = 4'h6;
    localparam logic [3:0] OpHalt  = 4'hF;

    state_e          state_q, state_d;
    logic [3:0]      op_q;
    logic [3:0]      op_live;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            fault_q, halted_q;
    logic            in_mem;
    logic            timeout;
    logic            unused_ir;

    assign op_live   = ir[IR_W-1 -: 4];
    assign unused_ir = ^ir[IR_W-5:0];
    assign in_mem    = (state_q == StFetch1) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout   = in_mem && !mem_ready && (wait_q == TO_W'(TIMEOUT - 1));

    // Next-state logic; memory states leave only on mem_ready or on timeout.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            StFetch0: state_d = StFetch1;
            StFetch1: begin
                if (mem_ready)    state_d = StFetch2;
                else if (timeout) state_d = StFault;
            end
            StFetch2: state_d = StDecode;
            StDecode: begin
                case (op_live)
                    OpLoad:  state_d = StMemRd;
                    OpStore: state_d = StWb;
                    OpPush:  state_d = StExa;
                    OpPop:   state_d = StMemRd;
                    OpAlu:   state_d = StExa;
                    OpHalt:  state_d = StHalt;
                    default: state_d = StFetch0;
                endcase
            end
            StExa:    state_d = (op_q == OpPush) ? StWb : StFetch0;
            StMemRd: begin
                if (mem_ready)    state_d = StWb;
                else if (timeout) state_d = StFault;
            end
            StMemWr: begin
                if (mem_ready)    state_d = StFetch0;
                else if (timeout) state_d = StFault;
            end
            StWb:     state_d = (op_q == OpStore || op_q == OpPush) ? StMemWr : StFetch0;
            StHalt:   state_d = StHalt;
            StFault:  state_d = StFault;
            default:  state_d = StFetch0;
        endcase
        // Counter runs only while an access stays pending; any entry starts it at zero.
        if (in_mem && (state_d == state_q)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch0;
            op_q     <= '0;
            wait_q   <= '0;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StDecode) begin
                op_q <= op_live;
            end
            if (state_d == StFault) begin
                fault_q <= 1'b1;
            end
            if (state_d == StHalt) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Moore decode; DECODE looks at the live opcode, later states at op_q.
    always_comb begin
        l_pc        = 1'b0;
        l_mar       = 1'b0;
        l_mdr       = 1'b0;
        l_ir        = 1'b0;
        l_sp        = 1'b0;
        l_y         = 1'b0;
        t_pc        = 1'b0;
        t_mar       = 1'b0;
        t_mdr       = 1'b0;
        t_ir        = 1'b0;
        t_sp        = 1'b0;
        t_y         = 1'b0;
        inc_pc      = 1'b0;
        inc_sp      = 1'b0;
        dec_sp      = 1'b0;
        y           = 1'b0;
        mem_active  = 1'b0;
        rd_wr       = 1'b0;
        retire      = 1'b0;
        err_illegal = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StFetch0: begin
                    t_pc  = 1'b1;
                    l_mar = 1'b1;
                end
                StFetch1, StMemRd: begin
                    mem_active = 1'b1;
                    rd_wr      = 1'b1;
                    l_mdr      = 1'b1;
                end
                StFetch2: begin
                    t_mdr  = 1'b1;
                    l_ir   = 1'b1;
                    inc_pc = 1'b1;
                end
                StDecode: begin
                    case (op_live)
                        OpNop: retire = 1'b1;
                        OpLoad, OpStore: begin
                            t_ir  = 1'b1;
                            l_mar = 1'b1;
                        end
                        OpPush: dec_sp = 1'b1;
                        OpPop: begin
                            t_sp  = 1'b1;
                            l_mar = 1'b1;
                        end
                        OpJmp: begin
                            t_ir   = 1'b1;
                            l_pc   = 1'b1;
                            retire = 1'b1;
                        end
                        OpAlu:  ;
                        OpHalt: retire = 1'b1;
                        default: begin
                            err_illegal = 1'b1;
                            retire      = 1'b1;
                        end
                    endcase
                end
                StExa: begin
                    if (op_q == OpPush) begin
                        t_sp  = 1'b1;
                        l_mar = 1'b1;
                    end else begin
                        y      = 1'b1;
                        l_y    = 1'b1;
                        retire = 1'b1;
                    end
                end
                StWb: begin
                    if (op_q == OpStore || op_q == OpPush) begin
                        t_y   = 1'b1;
                        l_mdr = 1'b1;
                    end else begin
                        t_mdr  = 1'b1;
                        l_y    = 1'b1;
                        inc_sp = (op_q == OpPop);
                        retire = 1'b1;
                    end
                end
                StMemWr: begin
                    mem_active = 1'b1;
                    retire     = mem_ready;
                end
                StHalt, StFault: ;
                default: ;
            endcase
        end
    end

    assign state  = state_q;
    assign fault  = fault_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against a per-instruction profile model, plus directed
// reset, timeout, halt and illegal-opcode scenarios.
module tb_multicycle_ctrl;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam int          NINSTR  = 150;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        l_pc, l_mar, l_mdr, l_ir, l_sp, l_y;
    logic        t_pc, t_mar, t_mdr, t_ir, t_sp, t_y;
    logic        inc_pc, inc_sp, dec_sp, y, mem_active, rd_wr;
    logic [3:0]  state;
    logic        retire, err_illegal, fault, halted;
    logic [19:0] ctl;

    assign ctl = {l_pc, l_mar, l_mdr, l_ir, l_sp, l_y, t_pc, t_mar, t_mdr, t_ir, t_sp, t_y,
                  inc_pc, inc_sp, dec_sp, y, mem_active, rd_wr, retire, err_illegal};

    always #5 clk = ~clk;

    multicycle_ctrl #(.IR_W(IR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ready(mem_ready),
        .l_pc(l_pc), .l_mar(l_mar), .l_mdr(l_mdr), .l_ir(l_ir), .l_sp(l_sp), .l_y(l_y),
        .t_pc(t_pc), .t_mar(t_mar), .t_mdr(t_mdr), .t_ir(t_ir), .t_sp(t_sp), .t_y(t_y),
        .inc_pc(inc_pc), .inc_sp(inc_sp), .dec_sp(dec_sp), .y(y),
        .mem_active(mem_active), .rd_wr(rd_wr), .state(state), .retire(retire),
        .err_illegal(err_illegal), .fault(fault), .halted(halted)
    );

    typedef struct packed {
        logic [7:0] lat, rd, wr, err, dsp, isp, alu, lpc, ipc, lir;
    } prof_t;

    int          checks = 0;
    int          errors = 0;
    prof_t       exp_q[$];
    logic [15:0] prog [NINSTR+1];
    int          wf   [NINSTR+1];
    int          wd   [NINSTR+1];
    bit          drv_en = 1'b0;
    bit          mon_en = 1'b0;
    int          idx = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Whole-instruction expectation from opcode class and memory wait counts.
    function automatic prof_t model(input logic [3:0] op, input int f, input int d);
        prof_t p;
        bit    rd_op, wr_op;
        int    lat;
        p     = '0;
        rd_op = (op == 4'h1) || (op == 4'h4);
        wr_op = (op == 4'h2) || (op == 4'h3);
        lat   = 4 + f;
        if (op == 4'h6) lat += 1;
        if (rd_op)      lat += 2 + d;
        if (op == 4'h2) lat += 2 + d;
        if (op == 4'h3) lat += 3 + d;
        p.lat = 8'(lat);
        p.rd  = 8'(1 + f + (rd_op ? 1 + d : 0));
        p.wr  = 8'(wr_op ? 1 + d : 0);
        p.err = 8'((op >= 4'h7 && op <= 4'hE) ? 1 : 0);
        p.dsp = 8'((op == 4'h3) ? 1 : 0);
        p.isp = 8'((op == 4'h4) ? 1 : 0);
        p.alu = 8'((op == 4'h6) ? 1 : 0);
        p.lpc = 8'((op == 4'h5) ? 1 : 0);
        p.ipc = 8'd1;
        p.lir = 8'd1;
        return p;
    endfunction

    // Datapath/memory responder: loads IR after l_ir, answers accesses after planned waits.
    initial begin : driver
        bit prev_lir = 1'b0;
        bit prev_ret = 1'b0;
        bit data_ph  = 1'b0;
        int acc      = 0;
        int w;
        forever begin
            @(posedge clk);
            #1;
            if (!drv_en) begin
                acc     = 0;
                data_ph = 1'b0;
            end else begin
                if (prev_ret) begin
                    idx++;
                    data_ph = 1'b0;
                end
                if (prev_lir && idx <= NINSTR) begin
                    ir      = prog[idx];
                    data_ph = 1'b1;
                    exp_q.push_back(model(prog[idx][15:12], wf[idx], wd[idx]));
                end
                if (mem_active && idx <= NINSTR) begin
                    w         = data_ph ? wd[idx] : wf[idx];
                    mem_ready = (acc == w);
                    acc++;
                end else begin
                    acc       = 0;
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            prev_lir = drv_en && l_ir;
            prev_ret = drv_en && retire;
        end
    end

    initial begin : monitor
        prof_t a;
        prof_t e;
        a = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                a = '0;
                continue;
            end
            chk("t_onehot", 128'($countones({t_pc, t_mar, t_mdr, t_ir, t_sp, t_y}) <= 1), 128'(1));
            if (mem_active) chk("read_loads_mdr", 128'(l_mdr), 128'(rd_wr));
            a.lat += 8'd1;
            if (mem_active && rd_wr)  a.rd += 8'd1;
            if (mem_active && !rd_wr) a.wr += 8'd1;
            a.err += 8'(err_illegal);
            a.dsp += 8'(dec_sp);
            a.isp += 8'(inc_sp);
            a.alu += 8'(y);
            a.lpc += 8'(l_pc);
            a.ipc += 8'(inc_pc);
            a.lir += 8'(l_ir);
            if (retire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retire with empty queue, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 128'(a.lat), 128'(e.lat));
                    chk("profile", 128'(a), 128'(e));
                end
                a = '0;
            end
        end
    end

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 128'(ctl), 128'(0));
        chk("reset_state", 128'(state), 128'(0));
        chk("reset_flags", 128'({fault, halted}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int exp_st [5] = '{0, 1, 2, 3, 0};
        int n_err;
        int lat;
        bit done;
        int op;

        for (int i = 0; i <= NINSTR; i++) begin
            op = int'($urandom_range(0, 9));
            if (op > 6) op = int'($urandom_range(7, 14));
            prog[i] = {4'(op), 12'($urandom)};
            wf[i]   = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            wd[i]   = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
        end
        prog[NINSTR] = {4'hF, 12'($urandom)};

        // Random program ending in HALT.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idx    = 0;
        rst_n  = 1'b1;
        drv_en = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 20000 && idx <= NINSTR; c++) @(posedge clk);
        if (idx <= NINSTR) begin
            checks++;
            errors++;
            $display("FAIL program_timeout: got %0d retired, expected %0d", idx, NINSTR + 1);
        end
        @(negedge clk);
        drv_en = 1'b0;
        mon_en = 1'b0;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", 128'({state, halted, fault}), 128'({4'd14, 1'b1, 1'b0}));
            chk("halt_outputs", 128'(ctl), 128'(0));
            @(negedge clk);
        end

        // NOP straight after reset with zero-wait memory.
        ir        = 16'h0000;
        mem_ready = 1'b1;
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nop_state", 128'(state), 128'(exp_st[i]));
            chk("nop_retire", 128'(retire), 128'(i == 3));
        end

        // Fetch timeout into FAULT, held until reset.
        mem_ready = 1'b0;
        reset_pulse();
        @(negedge clk);
        chk("to_fetch0", 128'(state), 128'(0));
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            chk("to_fetch1", 128'({state, mem_active, rd_wr}), 128'({4'd1, 1'b1, 1'b1}));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fault_state", 128'({state, fault, mem_active, retire}),
                128'({4'd15, 1'b1, 1'b0, 1'b0}));
        end
        mem_ready = 1'b1;
        reset_pulse();
        @(negedge clk);
        chk("after_fault_reset", 128'({state, fault}), 128'({4'd0, 1'b0}));

        // Reset mid-access drops mem_active without waiting for a clock.
        mem_ready = 1'b0;
        @(negedge clk);
        chk("midreset_active", 128'(mem_active), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_dropped", 128'({mem_active, state}), 128'({1'b0, 4'd0}));

        // mem_ready arrives in the last allowed wait cycle.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(posedge clk);
            #1;
            mem_ready = (i == int'(TIMEOUT) - 1);
            @(negedge clk);
            chk("late_fetch1", 128'(state), 128'(1));
        end
        @(negedge clk);
        chk("late_complete", 128'({state, fault}), 128'({4'd2, 1'b0}));

        // Illegal opcode: single err_illegal pulse, 4-cycle instruction.
        ir        = 16'h7000;
        mem_ready = 1'b1;
        reset_pulse();
        n_err = 0;
        lat   = 0;
        done  = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            lat++;
            n_err += int'(err_illegal);
            if (retire) done = 1'b1;
        end
        chk("illegal_retired", 128'(done), 128'(1));
        chk("illegal_latency", 128'(lat), 128'(4));
        chk("illegal_pulses", 128'(n_err), 128'(1));
        @(negedge clk);
        chk("illegal_next", 128'({state, err_illegal}), 128'({4'd0, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
